// File: rtl/ls74_pkg.sv
// Shared types and sizes for the 74LS165-style serializer.
// LS165_PARITY_EN selects the nine-slot (odd parity) frame length.
package ls74_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef LS165_PARITY_EN
  localparam logic [CNT_W-1:0] LAST = 4'd8;
`else
  localparam logic [CNT_W-1:0] LAST = 4'd7;
`endif

endpackage

// File: rtl/ls165_core.sv
// 8-bit parallel-load shift register modelled on the 74LS165.
// Load ignores clk_inh; shifting moves ser_in into bit 0 and exposes bit 7.
module ls165_core
  import ls74_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  input  logic              clk_inh,
  input  logic              ser_in,
  output logic              q_h
);

  logic [DATA_W-1:0] shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= load_data;
    end else if (shift && !clk_inh) begin
      shift_reg <= {shift_reg[DATA_W-2:0], ser_in};
    end
  end

  assign q_h = shift_reg[DATA_W-1];

endmodule

// File: rtl/ls165_piso_tx.sv
// Word-level serializer wrapping ls165_core: IDLE/SHIFT sequencer, slot counter and done pulse.
// Define LS165_PARITY_EN to append an odd-parity slot after D0.
module ls165_piso_tx
  import ls74_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              ser_in,
  input  logic              clk_inh,
  output logic              q_h,
  output logic              q_h_n,
  output logic              busy,
  output logic              done
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             done_next;
  logic             load;
  logic             shift;
  logic             core_q_h;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

  // The counter wraps to 0 on the final slot so it never exceeds LAST.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (!clk_inh) begin
          if (cnt == LAST) begin
            cnt_next   = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
    endcase
  end

  ls165_core u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (tx_data),
    .shift     (shift),
    .clk_inh   (clk_inh),
    .ser_in    (ser_in),
    .q_h       (core_q_h)
  );

`ifdef LS165_PARITY_EN
  logic parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= ~^tx_data;
    end
  end

  assign q_h = ((state == SHIFT) && (cnt == LAST)) ? parity : core_q_h;
`else
  assign q_h = core_q_h;
`endif

  assign q_h_n    = ~q_h;
  assign busy     = (state == SHIFT);
  assign tx_ready = (state == IDLE);

endmodule

// File: tb/tb_ls165_piso_tx.sv
// Directed bench for ls165_piso_tx; honours LS165_PARITY_EN for the ninth slot.
module tb_ls165_piso_tx;

`ifdef LS165_PARITY_EN
  localparam int LAST = 8;
`else
  localparam int LAST = 7;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ser_in;
  logic       clk_inh;
  logic       q_h;
  logic       q_h_n;
  logic       busy;
  logic       done;

  int         total = 0;
  int         bad   = 0;
  logic [15:0] exp16;
  logic [7:0]  word;

  ls165_piso_tx dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ser_in   (ser_in),
    .clk_inh  (clk_inh),
    .q_h      (q_h),
    .q_h_n    (q_h_n),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d,
                               input logic s, input logic inh);
    rst      = r;
    tx_valid = v;
    tx_data  = d;
    ser_in   = s;
    clk_inh  = inh;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One serial slot: expected bit on q_h, its complement, and frame flags.
  task automatic checkSlot(input string tag, input logic bit_exp);
    checkOutput({tag, " q_h"},   {7'd0, q_h},      {7'd0, bit_exp});
    checkOutput({tag, " q_h_n"}, {7'd0, q_h_n},    {7'd0, ~bit_exp});
    checkOutput({tag, " busy"},  {7'd0, busy},     8'd1);
    checkOutput({tag, " ready"}, {7'd0, tx_ready}, 8'd0);
    checkOutput({tag, " done"},  {7'd0, done},     8'd0);
  endtask

  task automatic checkDone(input string tag);
    checkOutput({tag, " done"},  {7'd0, done},     8'd1);
    checkOutput({tag, " ready"}, {7'd0, tx_ready}, 8'd1);
    checkOutput({tag, " busy"},  {7'd0, busy},     8'd0);
  endtask

  // exp_bits[8:1] are the eight data slots, exp_bits[0] the parity slot.
  task automatic runFrame(input string tag, input logic [7:0] data, input logic s,
                          input logic [8:0] exp_bits);
    applyStimulus(1'b0, 1'b1, data, s, 1'b0);
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i <= LAST; i++) begin
      checkSlot($sformatf("%s slot%0d", tag, i), exp_bits[8-i]);
      tick();
    end
    checkDone(tag);
  endtask

  initial begin
    // Reset wins over a simultaneous load request.
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("reset q_h",   {7'd0, q_h},      8'd0);
    checkOutput("reset q_h_n", {7'd0, q_h_n},    8'd1);
    checkOutput("reset busy",  {7'd0, busy},     8'd0);
    checkOutput("reset done",  {7'd0, done},     8'd0);
    checkOutput("reset ready", {7'd0, tx_ready}, 8'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("idle ready", {7'd0, tx_ready}, 8'd1);

    // Basic word 0xA5: 1,0,1,0,0,1,0,1 then parity 1.
    runFrame("a5", 8'hA5, 1'b0, 9'b1010_0101_1);
    tick();
    checkOutput("a5 done pulse", {7'd0, done}, 8'd0);

    // Inhibit: held during the load cycle (must not matter) and for 3 cycles at slot 2.
    applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    word = 8'hF0;
    checkSlot("inh slot0", 1'b1);
    tick();
    checkSlot("inh slot1", 1'b1);
    tick();
    clk_inh = 1'b1;
    checkSlot("inh slot2", 1'b1);
    tick();
    checkSlot("inh hold1", 1'b1);
    tick();
    checkSlot("inh hold2", 1'b1);
    tick();
    clk_inh = 1'b0;
    checkSlot("inh hold3", 1'b1);
    tick();
    for (int i = 3; i <= LAST; i++) begin
      checkSlot($sformatf("inh slot%0d", i), (i < 8) ? word[7-i] : 1'b1);
      tick();
    end
    checkDone("inh");
    tick();

    // Back-to-back 0x81 then 0x7E accepted in the done cycle; mid-frame valid ignored.
    exp16 = 16'b1000_0001_0111_1110;
    applyStimulus(1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i <= LAST; i++) begin
      checkSlot($sformatf("b2b0 slot%0d", i), (i < 8) ? exp16[15-i] : 1'b1);
      tick();
    end
    checkDone("b2b0");
    tx_data  = 8'h7E;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i <= LAST; i++) begin
      if (i == 3) begin
        tx_data  = 8'h00;
        tx_valid = 1'b1;
      end
      checkSlot($sformatf("b2b1 slot%0d", i), (i < 8) ? exp16[7-i] : 1'b1);
      tick();
      tx_valid = 1'b0;
    end
    checkDone("b2b1");
    tick();
    checkOutput("b2b idle busy",  {7'd0, busy},     8'd0);
    checkOutput("b2b idle ready", {7'd0, tx_ready}, 8'd1);

    // Reset at counter 4 of 0xFF aborts the frame with no done pulse.
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkSlot($sformatf("abort slot%0d", i), 1'b1);
      tick();
    end
    checkSlot("abort slot4", 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort q_h",   {7'd0, q_h},      8'd0);
    checkOutput("abort q_h_n", {7'd0, q_h_n},    8'd1);
    checkOutput("abort busy",  {7'd0, busy},     8'd0);
    checkOutput("abort ready", {7'd0, tx_ready}, 8'd1);
    checkOutput("abort done",  {7'd0, done},     8'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("abort nodone%0d", i), {7'd0, done}, 8'd0);
    end

    // Cascade: ser_in high while sending 0x00 refills the register with ones.
    runFrame("cascade", 8'h00, 1'b1, 9'b0000_0000_1);
    checkOutput("cascade q_h",   {7'd0, q_h},   8'd1);
    checkOutput("cascade q_h_n", {7'd0, q_h_n}, 8'd0);
    ser_in = 1'b0;
    tick();
    checkOutput("cascade hold q_h", {7'd0, q_h}, 8'd1);

`ifdef LS165_PARITY_EN
    runFrame("par03", 8'h03, 1'b0, 9'b0000_0011_1);
    tick();
    runFrame("par07", 8'h07, 1'b0, 9'b0000_0111_0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ls165_piso_tx.md
LS165_PISO_TX -- requirements
Module: ls165_piso_tx

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; no other clocks or asynchronous inputs.
REQ-002 SHALL have the port `clk`: input, 1 bit, single clock, all state updates on its rising edge.
REQ-003 SHALL have the port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have the port `tx_data`: input, 8 bits, parallel word to serialize; D7 is sent first.
REQ-005 SHALL have the port `tx_valid`: input, 1 bit, requests a load of `tx_data`.
REQ-006 SHALL have the port `tx_ready`: output, 1 bit, block can accept a word this cycle.
REQ-007 SHALL have the port `ser_in`: input, 1 bit, cascade serial input; shifted into bit 0 on each shift (74LS165 SER).
REQ-008 SHALL have the port `clk_inh`: input, 1 bit; high freezes the shift register and bit counter (74LS165 CLK INH).
REQ-009 SHALL have the port `q_h`: output, 1 bit, serial output equal to register bit 7 (or the parity bit during the parity slot).
REQ-010 SHALL have the port `q_h_n`: output, 1 bit, always the complement of `q_h`.
REQ-011 SHALL have the port `busy`: output, 1 bit, high while in SHIFT.
REQ-012 SHALL have the port `done`: output, 1 bit, one-cycle pulse after the last bit slot completes.

Function
REQ-013 SHALL implement the states IDLE and SHIFT.
REQ-014 SHALL drive `tx_ready` = 1 exactly when in IDLE.
REQ-015 When in IDLE and `tx_valid` & `tx_ready`, SHALL on the next edge load the register with `tx_data`, clear the bit counter to 0 and enter SHIFT.
REQ-016 SHALL make `q_h` equal D7 in the first SHIFT cycle, so load-to-first-bit latency is 1 cycle.
REQ-017 SHALL ignore `clk_inh` for the load itself.
REQ-018 In SHIFT with `clk_inh` = 0, each edge SHALL set reg <= {reg[6:0], `ser_in`} and increment the counter.
REQ-019 In SHIFT with `clk_inh` = 1, the register, counter and state SHALL all hold.
REQ-020 Bit slot i (i = 0..7) SHALL be presented on `q_h` while counter == i; slot i carries D(7-i).
REQ-021 On an enabled edge with counter == LAST (7, or 8 under REQ-029), the block SHALL return to IDLE and assert `done` for exactly the following cycle.
REQ-022 In IDLE the register SHALL hold its value, and `q_h` SHALL continue to show reg[7].
REQ-023 SHALL ignore `tx_valid` while in SHIFT; no word is queued.
REQ-024 Back-to-back words: in the `done` cycle `tx_ready` = 1, so a word presented then SHALL be accepted; the maximum rate is one word per LAST+2 cycles.
REQ-025 SHALL keep the counter 4 bits wide; the counter SHALL never exceed LAST.

Reset
REQ-026 `rst` SHALL take priority over all other inputs at any cycle, including mid-frame.
REQ-027 After reset: state = IDLE, register = 0x00, counter = 0, `q_h` = 0, `q_h_n` = 1, `busy` = 0, `done` = 0, `tx_ready` = 1.
REQ-028 Reset during SHIFT SHALL abort the frame with no `done` pulse.

Configuration
REQ-029 Macro `LS165_PARITY_EN` defined: SHALL latch odd parity (~^`tx_data`) at load, add a ninth slot (counter == 8) with `q_h` = parity, and set LAST = 8; `clk_inh` SHALL also stall the parity slot.
REQ-030 Macro `LS165_PARITY_EN` undefined: SHALL provide no parity slot, set LAST = 7, and generate no parity logic.

Structure
REQ-031 A shared package `ls74_pkg` SHALL hold the state enum {IDLE, SHIFT}, DATA_W = 8 and CNT_W = 4.
REQ-032 SHALL instantiate one sub-module, `ls165_core`, containing the 8-bit register with load, shift and inhibit, modelling the 74LS165.
REQ-033 The sequencer, counter and parity logic SHALL live in `ls165_piso_tx`.

Verification
REQ-034 Basic word: reset, then `tx_data` = 0xA5 with `tx_valid` for 1 cycle and `clk_inh` = 0 -> `q_h` = 1,0,1,0,0,1,0,1 on consecutive cycles, `done` in cycle 10 after accept, `tx_ready` = 1 in the same cycle.
REQ-035 Inhibit: 0xF0, `clk_inh` high for 3 cycles while counter == 2 -> `q_h` holds 1 for those 3 cycles, frame is 3 cycles longer, bit order unchanged.
REQ-036 Back-to-back and busy-ignore: 0x81, then 0x7E presented in the `done` cycle -> 16 contiguous bits 1000000101111110; a `tx_valid` pulse mid-frame leaves the output unaffected.
REQ-037 Reset mid-frame: `rst` at counter == 4 with 0xFF -> next cycle `q_h` = 0, `busy` = 0, `tx_ready` = 1, and no `done`.
REQ-038 Parity build (`LS165_PARITY_EN`): 0x03 -> ninth bit = 1; 0x07 -> ninth bit = 0; `done` after 9 slots.
REQ-039 Cascade: `ser_in` = 1 throughout 0x00 -> reg = 0xFF in IDLE after `done`, so `q_h` = 1 and `q_h_n` = 0.
